// File: rtl/rate_div_pkg.sv
// Shared definitions for the tick rate divider: rate-select encodings and
// the reload value helper used to set each tick period.
package rate_div_pkg;

   localparam logic [1:0] SEL_FULL = 2'b00;
   localparam logic [1:0] SEL_1HZ  = 2'b01;
   localparam logic [1:0] SEL_HALF = 2'b10;
   localparam logic [1:0] SEL_QTR  = 2'b11;

   localparam int RELOAD_W = 32;

   // The result is wide enough for any supported CLK_HZ; callers cast it
   // down to their own counter width.
   function automatic logic [RELOAD_W-1:0] reload_of(input logic [1:0] sel,
                                                     input int unsigned clk_hz);
      logic [RELOAD_W-1:0] r;
      r = '0;
      case (sel)
         SEL_FULL: r = '0;
         SEL_1HZ:  r = RELOAD_W'(clk_hz - 1);
         SEL_HALF: r = RELOAD_W'((2 * clk_hz) - 1);
         SEL_QTR:  r = RELOAD_W'((4 * clk_hz) - 1);
         default:  r = '0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/rate_divider_tick_if.sv
// Control and status bundle between the switch/button inputs and the
// rate divider; the divider takes the slave view.
interface rate_divider_tick_if;
   import rate_div_pkg::*;

   logic [1:0] sel;
   logic       pause;
   logic       step_n;
   logic       tick;
   logic       beat;

   modport master (
      output sel,
      output pause,
      output step_n,
      input  tick,
      input  beat
   );

   modport slave (
      input  sel,
      input  pause,
      input  step_n,
      output tick,
      output beat
   );

endinterface

// File: rtl/key_sync_edge.sv
// Brings a raw active-low push button into the clock domain and emits a
// one-cycle pulse on each press (released-to-pressed transition).
module key_sync_edge (
   input  logic clock,
   input  logic resetp,
   input  logic raw_n,
   output logic pulse
);

   logic sync_a;
   logic sync_b;
   logic sync_prev;

   // Two synchronizer stages plus a history flop; reset looks like a
   // released button so no false press appears when reset drops.
   always_ff @(posedge clock) begin
      if (resetp) begin
         sync_a    <= 1'b1;
         sync_b    <= 1'b1;
         sync_prev <= 1'b1;
      end else begin
         sync_a    <= raw_n;
         sync_b    <= sync_a;
         sync_prev <= sync_b;
      end
   end

   assign pulse = sync_prev & ~sync_b;

endmodule

// File: rtl/rate_divider_tick.sv
// Generates the single-cycle counter enable at a switch-selected rate, with a
// pause mode in which the push button single-steps the counter instead.
module rate_divider_tick
   import rate_div_pkg::*;
#(
   parameter int unsigned CLK_HZ = 50_000_000,
   parameter int          CNT_W  = 28
) (
   input  logic               clock,
   input  logic               resetp,
   rate_divider_tick_if.slave bus
);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] reload;
   logic [1:0]       sel_q;
   logic             step_edge;
   logic             tick_r;
   logic             beat_r;

   key_sync_edge u_step (
      .clock  (clock),
      .resetp (resetp),
      .raw_n  (bus.step_n),
      .pulse  (step_edge)
   );

   assign reload = CNT_W'(reload_of(bus.sel, CLK_HZ));

   // A speed change restarts the period and beats a coinciding terminal
   // count; otherwise the counter either runs or, when paused, holds while
   // button presses stand in for the terminal count.
   always_ff @(posedge clock) begin
      if (resetp) begin
         cnt    <= reload;
         sel_q  <= bus.sel;
         tick_r <= 1'b0;
         beat_r <= 1'b0;
      end else if (bus.sel != sel_q) begin
         cnt    <= reload;
         sel_q  <= bus.sel;
         tick_r <= 1'b0;
      end else if (!bus.pause) begin
         if (cnt == '0) begin
            cnt    <= reload;
            tick_r <= 1'b1;
            beat_r <= ~beat_r;
         end else begin
            cnt    <= cnt - CNT_W'(1);
            tick_r <= 1'b0;
         end
      end else begin
         tick_r <= step_edge;
         if (step_edge) begin
            beat_r <= ~beat_r;
         end
      end
   end

   assign bus.tick = tick_r;
   assign bus.beat = beat_r;

endmodule
